// File: rtl/proc_w_if.sv
// rtl/proc_w_if.sv - instruction/bus/status signal bundle between the board wrapper and proc_w
interface proc_w_if #(
  parameter int W = 16
);
  logic [W-1:0] DIN;
  logic         Run;
  logic         Done;
  logic [W-1:0] BusWires;
  logic         Zflag;
  logic         Cflag;

  modport master (
    output DIN,
    output Run,
    input  Done,
    input  BusWires,
    input  Zflag,
    input  Cflag
  );

  modport slave (
    input  DIN,
    input  Run,
    output Done,
    output BusWires,
    output Zflag,
    output Cflag
  );
endinterface

// File: rtl/proc_w.sv
// rtl/proc_w.sv - W-bit multi-cycle bus processor: R0-R7, A, G, eight opcodes, Z/C flags
// The interface instance must be built with the same W as this module.
module proc_w #(
  parameter int W = 16
) (
  input  logic     Clock,
  input  logic     Resetn,
  proc_w_if.slave  pif
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  // sel bit positions: 0..7 = R0..R7, 8 = G, 9 = DIN
  localparam int SEL_G   = 8;
  localparam int SEL_DIN = 9;

  state_t       state, state_nxt;
  logic [8:0]   ir;
  logic [W-1:0] r [8];
  logic [W-1:0] a, g;
  logic         z_q, c_q;

  logic [2:0]   op, rx, ry;
  logic         is_move;
  logic [9:0]   sel;
  logic         ir_we, a_we, g_we, rx_we, done;
  logic [W-1:0] bus_val;
  logic [W-1:0] alu_res;
  logic         alu_c;

  assign op      = ir[8:6];
  assign rx      = ir[5:3];
  assign ry      = ir[2:0];
  assign is_move = (op == OP_MV) || (op == OP_MVI) || (op == OP_MVNZ);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel       = '0;
    ir_we     = 1'b0;
    a_we      = 1'b0;
    g_we      = 1'b0;
    rx_we     = 1'b0;
    done      = 1'b0;
    case (state)
      T0: begin
        if (pif.Run) begin
          ir_we     = 1'b1;
          state_nxt = T1;
        end
      end
      T1: begin
        if (is_move) begin
          if (op == OP_MVI) begin
            sel[SEL_DIN] = 1'b1;
          end else begin
            sel = 10'd1 << ry;
          end
          // mvnz still drives Ry on the bus, it just suppresses the write
          rx_we     = (op != OP_MVNZ) || !z_q;
          done      = 1'b1;
          state_nxt = T0;
        end else begin
          sel       = 10'd1 << rx;
          a_we      = 1'b1;
          state_nxt = T2;
        end
      end
      T2: begin
        sel       = 10'd1 << ry;
        g_we      = 1'b1;
        state_nxt = T3;
      end
      T3: begin
        sel[SEL_G] = 1'b1;
        rx_we      = 1'b1;
        done       = 1'b1;
        state_nxt  = T0;
      end
      default: state_nxt = T0;
    endcase
  end

  always_comb begin
    bus_val = pif.DIN;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) begin
        bus_val = r[i];
      end
    end
    if (sel[SEL_G]) begin
      bus_val = g;
    end
    if (sel[SEL_DIN]) begin
      bus_val = pif.DIN;
    end
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD:  {alu_c, alu_res} = {1'b0, a} + {1'b0, bus_val};
      OP_SUB: begin
        alu_res = a - bus_val;
        alu_c   = (a < bus_val);
      end
      OP_AND:  alu_res = a & bus_val;
      OP_OR:   alu_res = a | bus_val;
      OP_XOR:  alu_res = a ^ bus_val;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ir  <= '0;
      a   <= '0;
      g   <= '0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r[i] <= '0;
      end
    end else begin
      if (ir_we) begin
        ir <= pif.DIN[W-1 -: 9];
      end
      if (a_we) begin
        a <= bus_val;
      end
      if (g_we) begin
        g   <= alu_res;
        z_q <= (alu_res == '0);
        c_q <= alu_c;
      end
      if (rx_we) begin
        r[rx] <= bus_val;
      end
    end
  end

  assign pif.Done     = done;
  assign pif.BusWires = bus_val;
  assign pif.Zflag    = z_q;
  assign pif.Cflag    = c_q;

endmodule

// File: tb/tb_proc_w.sv
// tb/tb_proc_w.sv - scoreboard bench for proc_w: driver queues expected Done-cycle results, monitor checks them
module tb_proc_w;

  localparam int W = 16;

  logic Clock;
  logic Resetn;
  int   cyc;
  int   total;
  int   passed;

  typedef struct {
    logic [W-1:0] bus;
    logic         z;
    logic         c;
    int           done_cyc;
    string        name;
  } exp_t;

  exp_t sbq [$];

  proc_w_if #(.W(W)) bus_if ();

  proc_w #(.W(W)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .pif    (bus_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every Done cycle retires the oldest expected instruction.
  always @(negedge Clock) begin
    if (Resetn && bus_if.Done) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got Done=1 expected no instruction pending (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, "_bus"}, 32'(bus_if.BusWires), 32'(e.bus));
        chk({e.name, "_z"},   32'(bus_if.Zflag),    32'(e.z));
        chk({e.name, "_c"},   32'(bus_if.Cflag),    32'(e.c));
        chk({e.name, "_lat"}, 32'(cyc),             32'(e.done_cyc));
      end
    end
  end

  task automatic issue(input logic [W-1:0] ins, input logic [W-1:0] imm,
                       input logic [W-1:0] eb, input logic ez, input logic ec,
                       input int lat, input string nm);
    exp_t e;
    bit   seen;
    @(posedge Clock); #1;
    bus_if.DIN = ins;
    bus_if.Run = 1'b1;
    e.bus      = eb;
    e.z        = ez;
    e.c        = ec;
    e.done_cyc = cyc + lat - 1;
    e.name     = nm;
    sbq.push_back(e);
    @(posedge Clock); #1;
    bus_if.Run = 1'b0;
    bus_if.DIN = imm;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge Clock);
      if (bus_if.Done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      $display("FAIL %s_timeout: got no Done expected Done within 8 cycles", nm);
    end
  endtask

  localparam logic [W-1:0] JUNK = 16'h5A5A;

  initial begin
    cyc        = 0;
    total      = 0;
    passed     = 0;
    Resetn     = 1'b0;
    bus_if.DIN = 16'h1234;
    bus_if.Run = 1'b0;
    #1;
    chk("rst_done", 32'(bus_if.Done),     32'd0);
    chk("rst_bus",  32'(bus_if.BusWires), 32'h1234);
    chk("rst_z",    32'(bus_if.Zflag),    32'd0);
    chk("rst_c",    32'(bus_if.Cflag),    32'd0);
    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      chk("idle_done",  32'(bus_if.Done),     32'd0);
      chk("idle_bus",   32'(bus_if.BusWires), 32'h1234);
      chk("idle_state", 32'(dut.state),       32'd0);
    end

    issue(16'h2000, 16'h0005, 16'h0005, 1'b0, 1'b0, 2, "mvi_r0");
    issue(16'h2400, 16'h0003, 16'h0003, 1'b0, 1'b0, 2, "mvi_r1");
    issue(16'h4080, JUNK,     16'h0008, 1'b0, 1'b0, 4, "add_r0_r1");
    issue(16'h6400, JUNK,     16'hFFFB, 1'b0, 1'b1, 4, "sub_borrow");
    issue(16'h6480, JUNK,     16'h0000, 1'b1, 1'b0, 4, "sub_self");
    issue(16'hC800, JUNK,     16'h0008, 1'b1, 1'b0, 2, "mvnz_skip");
    issue(16'h0900, JUNK,     16'h0000, 1'b1, 1'b0, 2, "r2_kept");
    issue(16'h2C00, 16'h00A5, 16'h00A5, 1'b1, 1'b0, 2, "mvi_r3");
    issue(16'h8D80, JUNK,     16'h00A5, 1'b0, 1'b0, 4, "and_self");
    issue(16'hC800, JUNK,     16'h0008, 1'b0, 1'b0, 2, "mvnz_take");
    issue(16'h0900, JUNK,     16'h0008, 1'b0, 1'b0, 2, "r2_moved");
    issue(16'h3000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 2, "mvi_r4");
    issue(16'h3400, 16'h0001, 16'h0001, 1'b0, 1'b0, 2, "mvi_r5");
    issue(16'h5280, JUNK,     16'h0000, 1'b1, 1'b1, 4, "add_ovf");
    issue(16'h3800, 16'hF0F0, 16'hF0F0, 1'b1, 1'b1, 2, "mvi_r6");
    issue(16'h3C00, 16'h0FF0, 16'h0FF0, 1'b1, 1'b1, 2, "mvi_r7");
    issue(16'h0700, JUNK,     16'hF0F0, 1'b1, 1'b1, 2, "mv_r1_r6");
    issue(16'h8780, JUNK,     16'h00F0, 1'b0, 1'b0, 4, "and_logic");
    issue(16'h0B00, JUNK,     16'hF0F0, 1'b0, 1'b0, 2, "mv_r2_r6");
    issue(16'hAB80, JUNK,     16'hFFF0, 1'b0, 1'b0, 4, "or_logic");
    issue(16'hFB80, JUNK,     16'hFF00, 1'b0, 1'b0, 4, "xor_logic");

    // add R0,R1 cut off by reset while in T2
    @(posedge Clock); #1;
    bus_if.DIN = 16'h4080;
    bus_if.Run = 1'b1;
    @(posedge Clock); #1;
    bus_if.Run = 1'b0;
    @(posedge Clock); #1;
    chk("mid_in_t2", 32'(dut.state), 32'd2);
    Resetn = 1'b0;
    #1;
    chk("mid_done",  32'(bus_if.Done), 32'd0);
    chk("mid_state", 32'(dut.state),   32'd0);
    repeat (2) @(posedge Clock);
    #1;
    chk("mid_r0", 32'(dut.r[0]), 32'd0);
    chk("mid_a",  32'(dut.a),    32'd0);
    chk("mid_g",  32'(dut.g),    32'd0);
    Resetn = 1'b1;

    issue(16'h3C00, 16'h1357, 16'h1357, 1'b0, 1'b0, 2, "post_mvi_r7");
    issue(16'h5F80, JUNK,     16'h26AE, 1'b0, 1'b0, 4, "post_add_r7");

    repeat (3) @(posedge Clock);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/proc_w.md
# proc_w

Parametrised multi-cycle processor core, successor to the 9-bit four-instruction datapath. It keeps the same bus-oriented structure: eight general registers R0–R7, accumulator A, result register G, tri-state-free bus multiplexer, and a 4-step control FSM. The data width is generalised, the instruction set grows to eight opcodes (logic ops and a conditional move), and Z/C status flags are added. It sits between the switch/key board wrapper and the bus LEDs, and is the base for the upcoming memory-attached core.

## Interface
- W, 16, data/bus width in bits; legal range 9..32.
- Clock  in  1  rising-edge clock for all state.
- Resetn  in  1  reset, asynchronous, active-low.
- DIN  in  W  instruction word (T0) or immediate data (mvi, T1).
- Run  in  1  start request, sampled in T0.
- Done  out  1  high in the final step of every instruction.
- BusWires  out  W  current bus value.
- Zflag  out  1  registered zero flag.
- Cflag  out  1  registered carry/borrow flag.

## Operation
- Instruction format is DIN[W-1:W-9] = III XXX YYY. I is the opcode, X is the destination/first operand register, Y is the source register. DIN[W-10:0] is ignored.
- Opcodes:
  - 000 mv: Rx←Ry.
  - 001 mvi: Rx←DIN.
  - 010 add: Rx←Rx+Ry.
  - 011 sub: Rx←Rx−Ry.
  - 100 and: Rx←Rx&Ry.
  - 101 or: Rx←Rx|Ry.
  - 110 mvnz: Rx←Ry only if Zflag=0.
  - 111 xor: Rx←Rx^Ry.
- FSM states T0..T3, state register reset to T0.
  - T0: IR←DIN if Run=1. Next state is T1 if Run=1, else T0.
  - T1:
    - mv/mvi/mvnz: bus source is Ry (mv, mvnz) or DIN (mvi). Rx written at the clock edge (for mvnz only when Zflag=0). Done=1. Next state T0.
    - ALU ops: bus source is Rx, A←bus. Next state T2.
  - T2: bus source is Ry. G←A op bus, Z/C updated. Next state T3.
  - T3: bus source is G, Rx←G, Done=1. Next state T0.
- Bus source select is one-hot across R0–R7, G and DIN. When no source is selected (T0), BusWires=DIN.
- Arithmetic is unsigned modulo 2^W.
  - add: C = carry out of bit W-1.
  - sub: C = borrow, i.e. 1 when A<bus (unsigned).
  - and/or/xor: C←0.
  - Z = (result==0), for all ALU ops.
- Flags change only in T2 of ALU ops. mv, mvi and mvnz leave flags unchanged.
- X==Y is legal:
  - add R3,R3 doubles R3.
  - sub R3,R3 gives 0 with Z=1.
- Reset values (async, immediate):
  - FSM T0, so Done=0.
  - R0–R7, A, G, IR, Zflag, Cflag all 0.
  - BusWires=DIN.

## Timing
- Latency measured from the T0 edge that captures the instruction:
  - mv/mvi/mvnz: 2 cycles, Done high during the 2nd cycle, Rx updated at the end of it.
  - ALU ops: 4 cycles, Done in T3, Rx and flags visible in the following T0.
- Run is sampled only in T0. Run changes during T1..T3 have no effect. Run held high issues back-to-back instructions with no idle cycle.
- For mvi, the immediate must be stable on DIN during T1. The instruction word must be stable during T0.
- Done is combinational from the FSM state and lasts exactly one cycle per instruction.
- Resetn asserted mid-instruction:
  - Done drops immediately.
  - No register write occurs at any edge while Resetn=0.
  - After release the FSM starts in T0.
- All register, flag and IR updates happen on the rising Clock edge. BusWires is combinational from the current state and register contents.

## Test plan
- Reset, then idle: Resetn pulsed low with Run=0 and DIN=0x1234 → Done=0, BusWires=0x1234, Zflag=Cflag=0, FSM stays in T0 for 10 cycles.
- mvi R0 then add: mvi R0 (DIN=0x2000, then 0x0005), mvi R1 (0x2400, then 0x0003), add R0,R1 (0x4080) → BusWires=8 in T3, Done only in T3, Z=0, C=0.
- sub with borrow: continuing, sub R1,R0 (0x6400) → R1=0xFFFB, C=1, Z=0; then sub R1,R1 → R1=0, Z=1, C=0.
- mvnz: with Z=1, mvnz R2,R0 → R2 unchanged (0), Done in T1; and R3,R3 on a nonzero R3 gives Z=0; then mvnz R2,R0 → R2=R0.
- Overflow and logic ops: mvi R4=0xFFFF, mvi R5=1, add R4,R5 → R4=0, Z=1, C=1; and/or/xor of 0xF0F0 with 0x0FF0 → 0x00F0, 0xFFF0, 0xFF00, C=0.
- Reset mid-operation: Resetn low during T2 of an add → no write to Rx, A=G=0, Done=0; the next instruction after release executes normally from T0.
